// File: rtl/jcount_pkg.sv
// Shared types and helpers for the Johnson counter sequencer.
// Latency: not applicable (types, constants and a combinational decode function).
// Backpressure: not applicable.
//
// Contents: FSM state type, default sequence length, and the phase decode
// used to turn a Johnson pattern back into its position in the sequence.
package jcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } jseq_state_t;

    // Default counter width and the matching sequence length (2N states).
    localparam int unsigned JC_N_DEFAULT = 4;
    localparam int unsigned JC_SEQ_LEN   = 2 * JC_N_DEFAULT;

    // Widest counter the phase decode supports; callers zero-extend into it.
    localparam int unsigned JC_MAXN = 32;

    // Phase index of a Johnson pattern of width n. Bit i of v is cnt[i],
    // cnt[0] being the bit that receives ~cnt[N-1] on each shift.
    // A legal pattern has at most one boundary between ones and zeros;
    // anything else decodes to 0.
    function automatic int unsigned johnson_phase(input logic [JC_MAXN-1:0] v,
                                                  input int unsigned       n);
        int unsigned ones;
        int unsigned trans;
        ones  = 0;
        trans = 0;
        for (int unsigned i = 0; i < JC_MAXN; i++) begin
            if (i < n && v[i]) begin
                ones++;
            end
        end
        for (int unsigned i = 1; i < JC_MAXN; i++) begin
            if (i < n && (v[i] != v[i-1])) begin
                trans++;
            end
        end
        if (trans > 1) begin
            return 0;
        end else if (v[0]) begin
            return ones;
        end else if (ones == 0) begin
            return 0;
        end else begin
            return 2 * n - ones;
        end
    endfunction

endpackage

// File: rtl/jcount_if.sv
// Command and status bundle between a command source and the Johnson sequencer.
// Latency: not applicable (wires only).
// Backpressure: cmd_valid/cmd_ready; a command transfers when both are high at posedge.
//
// Ports: cmd_valid/cmd_ready/cmd_steps/cmd_clear (command), pause (hold),
// cnt/phase (counter state), busy/done (status).
interface jcount_if #(
    parameter int N     = 4,
    parameter int STEPW = 8
) ();
    import jcount_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [STEPW-1:0]         cmd_steps;
    logic                     cmd_clear;
    logic                     pause;
    logic [0:N-1]             cnt;
    logic [$clog2(2*N)-1:0]   phase;
    logic                     busy;
    logic                     done;

    // Command source / pattern consumer side.
    modport master (
        output cmd_valid, cmd_steps, cmd_clear, pause,
        input  cmd_ready, cnt, phase, busy, done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_steps, cmd_clear, pause,
        output cmd_ready, cnt, phase, busy, done
    );

endinterface

// File: rtl/jcount_shift.sv
// Johnson shift register: cnt[0] <= ~cnt[N-1], cnt[i] <= cnt[i-1].
// Latency: one shift per clock with en high; clr takes effect at the next edge.
// Backpressure: none; en low simply holds the value.
//
// Ports: clk, rstN (sync, active-low), en (shift), clr (load zero, beats en),
// cnt (register value, cnt[0] is the MSB of the packed vector).
module jcount_shift #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         en,
    input  logic         clr,
    output logic [0:N-1] cnt
);

    logic [0:N-1] cnt_q;
    logic [0:N-1] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = {~cnt_q[N-1], cnt_q[0:N-2]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/jcount_sequencer.sv
// Runs a Johnson counter for a commanded number of steps, then pulses done.
// Latency: accept at edge k -> shifts at k+1..k+S (plus paused cycles), done in the cycle after the last shift.
// Backpressure: cmd_ready only in IDLE; commands offered during RUN/DONE are ignored, not queued.
//
// Ports: clk, rstN (sync, active-low), bus (jcount_if slave: command handshake,
// pause, cnt/phase outputs, busy/done status).
module jcount_sequencer #(
    parameter int N     = 4,
    parameter int STEPW = 8
) (
    input  logic     clk,
    input  logic     rstN,
    jcount_if.slave  bus
);
    import jcount_pkg::*;

    localparam int PW = $clog2(2 * N);

    jseq_state_t        state_q;
    jseq_state_t        state_d;
    logic [STEPW-1:0]   rem_q;
    logic [STEPW-1:0]   rem_d;
    logic               accept;
    logic               shift_en;
    logic               shift_clr;
    logic [0:N-1]       cnt_w;
    logic [JC_MAXN-1:0] cnt_ext;

    always_comb begin
        accept    = bus.cmd_valid && (state_q == IDLE);
        shift_en  = (state_q == RUN) && !bus.pause;
        shift_clr = accept && bus.cmd_clear;

        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rem_d   = bus.cmd_steps;
                    // A zero-step run still produces its done pulse.
                    state_d = (bus.cmd_steps != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (!bus.pause) begin
                    rem_d = rem_q - STEPW'(1);
                    if (rem_q == STEPW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    jcount_shift #(
        .N (N)
    ) u_shift (
        .clk  (clk),
        .rstN (rstN),
        .en   (shift_en),
        .clr  (shift_clr),
        .cnt  (cnt_w)
    );

    // Widen the counter so the package decode can serve any N up to JC_MAXN.
    always_comb begin
        cnt_ext = '0;
        for (int i = 0; i < N; i++) begin
            cnt_ext[i] = cnt_w[i];
        end
    end

    assign bus.cnt       = cnt_w;
    assign bus.phase     = PW'(johnson_phase(cnt_ext, N));
    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_jcount_sequencer.sv
// Self-checking bench for jcount_sequencer (N=4, STEPW=8).
// Directed vector table, a mid-cycle reset sequence, then random commands
// checked against a phase-index model of the Johnson sequence.
module tb_jcount_sequencer;

    localparam int N     = 4;
    localparam int STEPW = 8;

    logic clk;
    logic rstN;

    jcount_if #(.N(N), .STEPW(STEPW)) bus ();

    jcount_sequencer #(.N(N), .STEPW(STEPW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    typedef struct {
        bit       rst_n;
        bit       valid;
        bit [7:0] steps;
        bit       clear;
        bit       pause;
        bit [3:0] exp_cnt;
        bit [2:0] exp_phase;
        bit       exp_busy;
        bit       exp_done;
        bit       exp_ready;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, bit [7:0] s, bit c, bit p,
                                bit [3:0] ec, bit [2:0] ep, bit eb, bit ed, bit er);
        vec_t x;
        x.rst_n = r; x.valid = v; x.steps = s; x.clear = c; x.pause = p;
        x.exp_cnt = ec; x.exp_phase = ep; x.exp_busy = eb; x.exp_done = ed; x.exp_ready = er;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ec, input int ep,
                           input bit eb, input bit ed, input bit er);
        chk({tag, ".cnt"},   32'(bus.cnt),       32'(ec));
        chk({tag, ".phase"}, 32'(bus.phase),     32'(ep));
        chk({tag, ".busy"},  32'(bus.busy),      32'(eb));
        chk({tag, ".done"},  32'(bus.done),      32'(ed));
        chk({tag, ".ready"}, 32'(bus.cmd_ready), 32'(er));
    endtask

    // Johnson pattern at sequence position p: first N positions fill ones
    // from the left, the next N drain them from the left.
    function automatic logic [3:0] pat(input int p);
        int v;
        if (p <= N) v = ((1 << p) - 1) << (N - p);
        else        v = (1 << (2 * N - p)) - 1;
        return v[3:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int mp;
        n_vec = 0;
        n_err = 0;
        rstN = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_steps = '0;
        bus.cmd_clear = 1'b0;
        bus.pause     = 1'b0;

        // Reset held with a command offered: nothing may be accepted.
        repeat (3) tbl.push_back(mk(0,1,4,0,0, 4'b0000,0,0,0,1));
        // Five steps from a clear.
        tbl.push_back(mk(1,1,5,1,0, 4'b0000,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1100,2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1110,3,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1111,4,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0111,5,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0111,5,0,0,1));
        // Two steps continuing without clear.
        tbl.push_back(mk(1,1,2,0,0, 4'b0111,5,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0011,6,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0001,7,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0001,7,0,0,1));
        // Nine steps from clear: wraps through 0000 on the 8th shift.
        tbl.push_back(mk(1,1,9,1,0, 4'b0000,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1100,2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1110,3,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1111,4,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0111,5,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0011,6,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0001,7,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b0000,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1000,1,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1000,1,0,0,1));
        // Three steps with two paused cycles after the first shift.
        tbl.push_back(mk(1,1,3,1,0, 4'b0000,0,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,1, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,1, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1100,2,1,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1110,3,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1110,3,0,0,1));
        // Zero-step command: done straight after acceptance, no shift.
        tbl.push_back(mk(1,1,0,0,0, 4'b1110,3,1,1,0));
        tbl.push_back(mk(1,0,0,0,0, 4'b1110,3,0,0,1));
        // Commands during RUN are ignored; reset after two shifts aborts silently.
        tbl.push_back(mk(1,1,6,1,0, 4'b0000,0,1,0,0));
        tbl.push_back(mk(1,1,3,0,0, 4'b1000,1,1,0,0));
        tbl.push_back(mk(1,1,3,1,0, 4'b1100,2,1,0,0));
        tbl.push_back(mk(0,1,3,0,0, 4'b0000,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0, 4'b0000,0,0,0,1));

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rstN          = tbl[i].rst_n;
            bus.cmd_valid = tbl[i].valid;
            bus.cmd_steps = tbl[i].steps;
            bus.cmd_clear = tbl[i].clear;
            bus.pause     = tbl[i].pause;
            tick();
            chk_all($sformatf("row%0d", i), tbl[i].exp_cnt, int'(tbl[i].exp_phase),
                    tbl[i].exp_busy, tbl[i].exp_done, tbl[i].exp_ready);
        end

        // Reset dropped between edges only acts at the next posedge.
        bus.cmd_valid = 1'b1; bus.cmd_steps = 8'd5; bus.cmd_clear = 1'b1; bus.pause = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        rstN = 1'b0;
        #2;
        chk("midrst.busy_hold", 32'(bus.busy), 32'd1);
        chk("midrst.cnt_hold",  32'(bus.cnt),  32'(4'b1000));
        tick();
        chk_all("midrst.after", 4'b0000, 0, 0, 0, 1);
        rstN = 1'b1;
        mp = 0;

        // Random commands against a sequence-position model.
        for (int c = 0; c < 40; c++) begin
            int s;
            int shifts;
            int guard;
            bit clr;
            bit p;
            repeat ($urandom_range(0, 2)) begin
                bus.cmd_valid = 1'b0;
                bus.pause = 1'($urandom_range(0, 1));
                tick();
                chk_all($sformatf("rnd%0d.idle", c), pat(mp), mp, 0, 0, 1);
            end
            s   = $urandom_range(0, 20);
            clr = 1'($urandom_range(0, 1));
            bus.cmd_valid = 1'b1;
            bus.cmd_steps = 8'(s);
            bus.cmd_clear = clr;
            bus.pause     = 1'($urandom_range(0, 1));
            tick();
            bus.cmd_valid = 1'b0;
            if (clr) mp = 0;
            shifts = 0;
            guard  = 0;
            while (shifts < s && guard < 200) begin
                chk_all($sformatf("rnd%0d.run", c), pat(mp), mp, 1, 0, 0);
                p = ($urandom_range(0, 9) < 3);
                bus.pause = p;
                bus.cmd_valid = 1'($urandom_range(0, 1));
                tick();
                if (!p) begin
                    shifts++;
                    mp = (mp + 1) % (2 * N);
                end
                guard++;
            end
            bus.cmd_valid = 1'b0;
            if (guard >= 200) begin
                chk($sformatf("rnd%0d.budget", c), 32'(guard), 32'd0);
            end
            chk_all($sformatf("rnd%0d.done", c), pat(mp), mp, 1, 1, 0);
            bus.pause = 1'($urandom_range(0, 1));
            tick();
            chk_all($sformatf("rnd%0d.back", c), pat(mp), mp, 0, 0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
